ctrl_bus_arbiter: RTL

Shares the 32-bit control-word bus between the CPU control logic (microcode ROM sequencer) and an external host such as the debugger or bootloader, which injects raw control words. Ownership changes only at instruction boundaries, with dead turnaround cycles on the bus. The CPU resumes from microstep 0 after the host releases the bus. Sits between the control logic's `ctrlen` input and the shared tri-state control-word bus.

---
 rtl/ctrl_bus_arbiter_if.sv | 31 +++
 rtl/ctrl_bus_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/ctrl_bus_arbiter_if.sv
// Host/control-logic handshake bundle for the control-word bus arbiter.
// The tri-state bus itself stays a plain port on the arbiter.
interface ctrl_bus_arbiter_if;
  logic        host_req;
  logic [31:0] host_cword;
  logic        step_reset;
  logic        ctrlen;
  logic        host_grant;
  logic        step_clear;
  logic        timeout;

  modport master (
    output host_req,
    output host_cword,
    output step_reset,
    input  ctrlen,
    input  host_grant,
    input  step_clear,
    input  timeout
  );

  modport slave (
    input  host_req,
    input  host_cword,
    input  step_reset,
    output ctrlen,
    output host_grant,
    output step_clear,
    output timeout
  );
endinterface

// File: rtl/ctrl_bus_arbiter.sv
// Control-word bus arbiter: CPU microcode vs external host, switching
// only at instruction boundaries with dead turnaround cycles between.
module ctrl_bus_arbiter #(
  parameter int TURN_CYCLES  = 1,
  parameter int HOST_TIMEOUT = 255
) (
  input  logic                iclk,
  input  logic                rst,
  ctrl_bus_arbiter_if.slave   bus,
  output logic [31:0]         control_word
);

  typedef enum logic [1:0] {
    CPU,
    TURN_H,
    HOST,
    TURN_C
  } state_t;

  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);
  localparam logic [3:0] TURN_PEN  = 4'(TURN_CYCLES - 2);
  localparam logic       ONE_TURN  = (TURN_CYCLES == 1);
  localparam logic [7:0] WD_LAST   = 8'(HOST_TIMEOUT - 1);
  localparam logic       WD_ON     = (HOST_TIMEOUT != 0);

  state_t     state;
  logic [3:0] turn_cnt;
  logic [7:0] wd_cnt;
  logic       armed;
  logic       ctrlen_q;
  logic       grant_q;
  logic       clear_q;
  logic       timeout_q;

  logic turn_last;
  logic wd_expire;

  assign turn_last = (turn_cnt == TURN_LAST);
  assign wd_expire = WD_ON && (wd_cnt == WD_LAST);

  always_ff @(posedge iclk) begin
    if (rst) begin
      state     <= CPU;
      turn_cnt  <= '0;
      wd_cnt    <= '0;
      armed     <= 1'b1;
      ctrlen_q  <= 1'b0;
      grant_q   <= 1'b0;
      clear_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state)
        CPU: begin
          if (!bus.host_req)
            armed <= 1'b1;
          if (bus.host_req && bus.step_reset && armed) begin
            state    <= TURN_H;
            turn_cnt <= '0;
            ctrlen_q <= 1'b1;
          end
        end
        TURN_H: begin
          if (turn_last) begin
            turn_cnt <= '0;
            if (bus.host_req) begin
              state     <= HOST;
              grant_q   <= 1'b1;
              wd_cnt    <= '0;
              timeout_q <= 1'b0;
            end else begin
              state   <= TURN_C;
              clear_q <= ONE_TURN;
            end
          end else begin
            turn_cnt <= turn_cnt + 4'd1;
          end
        end
        HOST: begin
          wd_cnt <= wd_cnt + 8'd1;
          if (!bus.host_req || wd_expire) begin
            state    <= TURN_C;
            grant_q  <= 1'b0;
            turn_cnt <= '0;
            clear_q  <= ONE_TURN;
            // a release on the expiry edge wins over eviction
            if (bus.host_req) begin
              timeout_q <= 1'b1;
              armed     <= 1'b0;
            end
          end
        end
        TURN_C: begin
          if (turn_last) begin
            state    <= CPU;
            turn_cnt <= '0;
            ctrlen_q <= 1'b0;
            clear_q  <= 1'b0;
          end else begin
            turn_cnt <= turn_cnt + 4'd1;
            clear_q  <= (turn_cnt == TURN_PEN);
          end
        end
        default: state <= CPU;
      endcase
    end
  end

  assign bus.ctrlen     = ctrlen_q;
  assign bus.host_grant = grant_q;
  assign bus.step_clear = clear_q;
  assign bus.timeout    = timeout_q;

  assign control_word = grant_q ? bus.host_cword : {32{1'bz}};

endmodule
